dcache_assoc: RTL and testbench

Parametrised N-way set-associative, write-back, write-allocate data cache for the pipelined CPU. It replaces the one-way `dcache_top` between the EX_MEM/MEM_WB stages and the 256-bit Data Memory interface. It adds configurable way/set count, true-LRU replacement, and dirty write-back. CPU-side port names and semantics are unchanged, so the pipeline's `memstall_i` wiring stays as is.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_lru.sv | 70 +++++++
 rtl/dcache_assoc.sv | 180 ++++++++++++++++++
 tb/tb_dcache_assoc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        REFILL
    } state_e;

    // Byte-offset bits inside one cache line.
    function automatic int off_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    // Set-index bits.
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: whatever remains above index and offset.
    function automatic int tag_bits(input int addr_bits, input int line_bits, input int sets);
        return addr_bits - off_bits(line_bits) - idx_bits(sets);
    endfunction

    // LRU age width; a direct-mapped cache still keeps one bit so vectors never collapse to zero width.
    function automatic int age_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// True-LRU bookkeeping: per-set age vectors and victim selection.
// Ways are passed as one-hot vectors so a one-way cache needs no special case.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [idx_bits(SETS)-1:0]   i_idx,
    input  logic                        i_hit,
    input  logic [WAYS-1:0]             i_hit_way,
    input  logic [WAYS-1:0]             i_valid,
    output logic [WAYS-1:0]             o_victim
);

    localparam int AGE_W = age_bits(WAYS);

    logic [AGE_W-1:0] r_age [SETS][WAYS];
    logic [AGE_W-1:0] w_hit_age;
    logic             w_found;

    // Age the hit way currently holds; everything younger than it moves one step older.
    always_comb begin
        w_hit_age = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (i_hit_way[w]) begin
                w_hit_age = w_hit_age | r_age[i_idx][w];
            end
        end
    end

    // Victim: lowest-numbered invalid way, otherwise the oldest way.
    always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!i_valid[w] && !w_found) begin
                o_victim[w] = 1'b1;
                w_found     = 1'b1;
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++) begin
                o_victim[w] = (r_age[i_idx][w] == AGE_W'(WAYS - 1));
            end
        end
    end

    // Age update on every completed hit; reset gives way w age w.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= AGE_W'(w);
                end
            end
        end else if (i_hit) begin
            for (int w = 0; w < WAYS; w++) begin
                if (i_hit_way[w]) begin
                    r_age[i_idx][w] <= '0;
                end else if (r_age[i_idx][w] < w_hit_age) begin
                    r_age[i_idx][w] <= r_age[i_idx][w] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache between the
// CPU MEM stage and a line-wide data memory.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] p1_data_i,
    input  logic [ADDR_BITS-1:0] p1_addr_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [DATA_BITS-1:0] p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);

    localparam int OFF_W = off_bits(LINE_BITS);
    localparam int IDX_W = idx_bits(SETS);
    localparam int TAG_W = tag_bits(ADDR_BITS, LINE_BITS, SETS);

    // Storage arrays
    logic [TAG_W-1:0]     r_tag   [SETS][WAYS];
    logic [LINE_BITS-1:0] r_line  [SETS][WAYS];
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-1:0]      r_dirty [SETS];

    // Miss-handling state, latched when a miss is accepted
    state_e           r_state;
    logic [WAYS-1:0]  r_victim;
    logic [TAG_W-1:0] r_wb_tag;
    logic [TAG_W-1:0] r_req_tag;
    logic [IDX_W-1:0] r_idx;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [OFF_W-3:0]     w_wsel;
    logic                 w_req;
    logic [WAYS-1:0]      w_hit_way;
    logic                 w_hit;
    logic [LINE_BITS-1:0] w_hit_line;
    logic [WAYS-1:0]      w_victim;
    logic [TAG_W-1:0]     w_victim_tag;
    logic [LINE_BITS-1:0] w_wb_line;
    logic                 w_victim_dirty;
    logic                 w_do_hit;
    logic                 w_do_write;
    logic                 w_miss_start;
    logic                 w_refill_done;
    state_e               w_state_nxt;
    logic                 w_unused;

    assign w_unused = ^p1_addr_i[1:0];

    assign w_idx  = p1_addr_i[OFF_W +: IDX_W];
    assign w_tag  = p1_addr_i[ADDR_BITS-1 -: TAG_W];
    assign w_wsel = p1_addr_i[OFF_W-1:2];
    assign w_req  = p1_MemRead_i | p1_MemWrite_i;

    // Tag compare across the addressed set.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_hit_way[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
        end
    end

    // Line muxes for the hit way, the candidate victim and the latched victim.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_hit_line   = '0;
        w_victim_tag = '0;
        w_wb_line    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit_way[w]) w_hit_line   = w_hit_line | r_line[w_idx][w];
            if (w_victim[w])  w_victim_tag = w_victim_tag | r_tag[w_idx][w];
            if (r_victim[w])  w_wb_line    = w_wb_line | r_line[r_idx][w];
        end
    end

    assign w_hit          = |w_hit_way;
    assign w_victim_dirty = |(w_victim & r_valid[w_idx] & r_dirty[w_idx]);
    assign w_do_hit       = w_req & w_hit & (r_state == IDLE);
    assign w_do_write     = w_do_hit & p1_MemWrite_i;
    assign w_miss_start   = w_req & ~w_hit & (r_state == IDLE);
    assign w_refill_done  = (r_state == REFILL) & mem_ack_i;

    assign p1_data_o  = (w_req & w_hit) ? w_hit_line[int'(w_wsel)*DATA_BITS +: DATA_BITS] : '0;
    assign p1_stall_o = w_req & ((r_state != IDLE) | ~w_hit);

    assign mem_enable_o = (r_state != IDLE);
    assign mem_write_o  = (r_state == WBACK);
    assign mem_data_o   = (r_state == WBACK) ? w_wb_line : '0;
    assign mem_addr_o   = (r_state == WBACK)  ? {r_wb_tag,  r_idx, {OFF_W{1'b0}}} :
                          (r_state == REFILL) ? {r_req_tag, r_idx, {OFF_W{1'b0}}} : '0;

    dcache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_idx     (w_idx),
        .i_hit     (w_do_hit),
        .i_hit_way (w_hit_way),
        .i_valid   (r_valid[w_idx]),
        .o_victim  (w_victim)
    );

    // Miss FSM next state: write back a dirty victim first, then refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_miss_start) w_state_nxt = w_victim_dirty ? WBACK : REFILL;
            WBACK:   if (mem_ack_i)    w_state_nxt = REFILL;
            REFILL:  if (mem_ack_i)    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state and latched miss context.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_victim  <= '0;
            r_wb_tag  <= '0;
            r_req_tag <= '0;
            r_idx     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss_start) begin
                r_victim  <= w_victim;
                r_wb_tag  <= w_victim_tag;
                r_req_tag <= w_tag;
                r_idx     <= w_idx;
            end
        end
    end

    // Valid and dirty bits: set on refill completion, dirty set by store hits.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else if (w_refill_done) begin
            r_valid[r_idx] <= r_valid[r_idx] | r_victim;
            r_dirty[r_idx] <= r_dirty[r_idx] & ~r_victim;
        end else if (w_do_write) begin
            r_dirty[w_idx] <= r_dirty[w_idx] | w_hit_way;
        end
    end

    // Tag and line storage: refill installs a line, store hits merge one word.
    // NOTE: tag/line arrays have no reset; valid bits gate every use, so clearing them suffices.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w_refill_done && r_victim[w]) begin
                    r_tag[r_idx][w]  <= r_req_tag;
                    r_line[r_idx][w] <= mem_data_i;
                end else if (w_do_write && w_hit_way[w]) begin
                    r_line[w_idx][w][int'(w_wsel)*DATA_BITS +: DATA_BITS] <= p1_data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc: a directed vector table on the 2-way/16-set
// configuration, a mid-refill reset sequence, and random traffic on 1-way and
// 4-way / 4-set instances checked against a golden memory and an LRU reference.
module tb_dcache_assoc;

    localparam int LAT  = 10;
    localparam int NDUT = 3;
    localparam int NV   = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_i;
    logic                  inject_ack;
    logic [NDUT-1:0]       cpu_rd, cpu_wr, stall;
    logic [NDUT-1:0][31:0] cpu_addr, cpu_wdata, rdata;
    logic [NDUT-1:0][7:0]  hitv;

    int total = 0;
    int bad   = 0;

    logic [31:0] gold [int];
    logic [31:0] exp_q [$];

    int ref_tag   [NDUT][16][8];
    bit ref_dirty [NDUT][16][8];
    int ref_cnt   [NDUT][16];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        string       name;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        localparam int S = (g == 0) ? 16 : 4;

        logic [255:0] mdi = '0;
        logic [255:0] mdo;
        logic [31:0]  maddr;
        logic         men, mwr, mack;
        logic         model_ack = 1'b0;
        logic [255:0] bmem [int];
        int           cnt = 0;
        int           k = 0;
        int           n_refill = 0;
        logic [31:0]  last_wb_addr = '0;
        logic [31:0]  last_rf_addr = '0;
        logic [255:0] last_wb_line = '0;

        dcache_assoc #(.WAYS(W), .SETS(S)) u_dut (
            .clk_i         (clk),
            .rst_i         (rst_i),
            .p1_data_i     (cpu_wdata[g]),
            .p1_addr_i     (cpu_addr[g]),
            .p1_MemRead_i  (cpu_rd[g]),
            .p1_MemWrite_i (cpu_wr[g]),
            .p1_data_o     (rdata[g]),
            .p1_stall_o    (stall[g]),
            .mem_data_i    (mdi),
            .mem_ack_i     (mack),
            .mem_data_o    (mdo),
            .mem_addr_o    (maddr),
            .mem_enable_o  (men),
            .mem_write_o   (mwr)
        );

        assign mack    = model_ack | ((g == 0) ? inject_ack : 1'b0);
        assign hitv[g] = 8'(u_dut.w_hit_way);

        // Memory model: acks on the LAT-th cycle of each enabled transaction.
        always @(negedge clk) begin
            model_ack = 1'b0;
            if (!men) begin
                cnt = 0;
            end else begin
                cnt = cnt + 1;
                if (cnt == LAT) begin
                    cnt       = 0;
                    model_ack = 1'b1;
                    k         = int'(maddr >> 5);
                    if (mwr) begin
                        bmem[k]      = mdo;
                        last_wb_addr = maddr;
                        last_wb_line = mdo;
                    end else begin
                        if (bmem.exists(k)) mdi = bmem[k];
                        else for (int i = 0; i < 8; i++) mdi[i*32 +: 32] = init_word(maddr + 32'(i * 4));
                        last_rf_addr = maddr;
                        n_refill++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // True-LRU reference kept as an MRU-first list per set; returns expected stall cycles.
    function automatic int ref_access(input int d, input int ways, input int sets,
                                      input logic [31:0] addr, input bit wr);
        int idx, tag, pos, st;
        bit dt;
        idx = int'(addr >> 5) % sets;
        tag = int'(addr >> 5) / sets;
        pos = -1;
        for (int i = 0; i < ref_cnt[d][idx]; i++) if (ref_tag[d][idx][i] == tag) pos = i;
        if (pos >= 0) begin
            dt = ref_dirty[d][idx][pos] | wr;
            st = 0;
        end else if (ref_cnt[d][idx] < ways) begin
            pos = ref_cnt[d][idx];
            ref_cnt[d][idx]++;
            dt = wr;
            st = LAT + 1;
        end else begin
            pos = ways - 1;
            st  = ref_dirty[d][idx][pos] ? 2 * LAT + 1 : LAT + 1;
            dt  = wr;
        end
        for (int i = pos; i > 0; i--) begin
            ref_tag[d][idx][i]   = ref_tag[d][idx][i-1];
            ref_dirty[d][idx][i] = ref_dirty[d][idx][i-1];
        end
        ref_tag[d][idx][0]   = tag;
        ref_dirty[d][idx][0] = dt;
        return st;
    endfunction

    // One CPU access: drive at negedge, count stall cycles, compare data when the request completes.
    task automatic do_access(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_stall, input string name);
        int n, hot, key;
        key = (d << 24) | int'(addr[23:0]);
        @(negedge clk);
        cpu_rd[d]    = rd;
        cpu_wr[d]    = wr;
        cpu_addr[d]  = addr;
        cpu_wdata[d] = wdata;
        if (wr) gold[key] = wdata;
        else    exp_q.push_back(gold.exists(key) ? gold[key] : init_word(addr));
        n   = 0;
        hot = 0;
        forever begin
            #1;
            if ($countones(hitv[d]) > hot) hot = $countones(hitv[d]);
            if (!stall[d] || n > 200) break;
            n++;
            @(negedge clk);
        end
        check({name, " stall"}, n, exp_stall);
        check({name, " onehot"}, hot <= 1, 1'b1);
        if (!wr) check({name, " data"}, rdata[d], exp_q.pop_front());
        @(posedge clk);
        #1;
        cpu_rd[d] = 1'b0;
        cpu_wr[d] = 1'b0;
    endtask

    initial begin
        int n, guard, exp_st, ways;
        bit wr;
        logic [31:0] a;

        rst_i      = 1'b0;
        inject_ack = 1'b0;
        cpu_rd     = '0;
        cpu_wr     = '0;
        cpu_addr   = '0;
        cpu_wdata  = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'h040, 32'h0,         LAT + 1,     "cold_rd_40"};
        vecs[1]  = '{1'b0, 1'b1, 32'h044, 32'hDEADBEEF,  0,           "wr_hit_44"};
        vecs[2]  = '{1'b1, 1'b0, 32'h044, 32'h0,         0,           "rd_hit_44"};
        vecs[3]  = '{1'b1, 1'b0, 32'h244, 32'h0,         LAT + 1,     "fill_B_244"};
        vecs[4]  = '{1'b1, 1'b0, 32'h044, 32'h0,         0,           "touch_A_44"};
        vecs[5]  = '{1'b1, 1'b0, 32'h444, 32'h0,         LAT + 1,     "evict_B_444"};
        vecs[6]  = '{1'b1, 1'b0, 32'h644, 32'h0,         2 * LAT + 1, "evict_A_644"};
        vecs[7]  = '{1'b1, 1'b0, 32'h044, 32'h0,         LAT + 1,     "reload_44"};
        vecs[8]  = '{1'b1, 1'b1, 32'h080, 32'h12345678,  LAT + 1,     "rdwr_80"};
        vecs[9]  = '{1'b1, 1'b0, 32'h080, 32'h0,         0,           "rd_80"};
        vecs[10] = '{1'b1, 1'b0, 32'h280, 32'h0,         LAT + 1,     "fill_280"};
        vecs[11] = '{1'b1, 1'b0, 32'h480, 32'h0,         2 * LAT + 1, "evict_dirty_80"};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst mem_enable", g_dut[0].men, 1'b0);
        check("rst mem_write",  g_dut[0].mwr, 1'b0);
        check("rst mem_addr",   g_dut[0].maddr, 32'h0);
        check("rst mem_data",   g_dut[0].mdo, 256'h0);
        check("rst p1_data",    rdata[0], 32'h0);
        check("rst p1_stall",   stall[0], 1'b0);
        rst_i = 1'b1;

        // Directed table on the 2-way / 16-set instance
        for (int i = 0; i < NV; i++) begin
            do_access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall, vecs[i].name);
            if (i == 0) begin
                check("cold refill count", g_dut[0].n_refill, 1);
                check("cold refill addr",  g_dut[0].last_rf_addr, 32'h040);
            end
            if (i == 6) begin
                check("wb addr",        g_dut[0].last_wb_addr, 32'h040);
                check("wb word1",       g_dut[0].last_wb_line[63:32], 32'hDEADBEEF);
                check("post-wb rf addr", g_dut[0].last_rf_addr, 32'h640);
            end
        end

        // Reset during refill cycle 5, then a stray ack while idle
        @(negedge clk);
        cpu_rd[0]   = 1'b1;
        cpu_addr[0] = 32'h840;
        n     = 0;
        guard = 0;
        while (n < 5 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (g_dut[0].men && !g_dut[0].mwr) n++;
        end
        check("rst reach refill5", n, 5);
        rst_i     = 1'b0;
        cpu_rd[0] = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        check("midrst mem_enable", g_dut[0].men, 1'b0);
        check("midrst stall",      stall[0], 1'b0);
        inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        check("late ack mem_enable", g_dut[0].men, 1'b0);
        check("late ack mem_addr",   g_dut[0].maddr, 32'h0);
        do_access(0, 1'b1, 1'b0, 32'h040, 32'h0, LAT + 1, "post_rst_40");

        // Random load/store sweep on the 1-way and 4-way instances
        for (int d = 1; d < NDUT; d++) begin
            ways = (d == 1) ? 1 : 4;
            for (int i = 0; i < 150; i++) begin
                wr     = 1'($urandom_range(0, 1));
                a      = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                exp_st = ref_access(d, ways, 4, a, wr);
                do_access(d, ~wr, wr, a, $urandom, exp_st, $sformatf("sweep%0d_%0d", d, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
